router_fifo: RTL and testbench
==============================

ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries (power of two).
REQ-002 Parameter TIMEOUT, default 30, idle cycles before soft-reset flush.
REQ-003 clock  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 write_enb  input  1  write request from upstream register stage.
REQ-006 lfd_state  input  1  marks data_in as packet header byte.
REQ-007 data_in  input  8  byte to store.
REQ-008 read_enb  input  1  read request from destination.
REQ-009 data_out  output  8  byte read out.
REQ-010 vld_out  output  1  FIFO non-empty.
REQ-011 full  output  1  FIFO holds DEPTH entries.
REQ-012 empty  output  1  FIFO holds zero entries.
REQ-013 soft_reset  output  1  one-cycle pulse on timeout flush.

Function
REQ-014 Storage SHALL be DEPTH x 9 bits; bit 8 = lfd_state captured with the byte.
REQ-015 Write and read pointers SHALL be log2(DEPTH)+1 bits; extra MSB is the wrap bit.
REQ-016 full SHALL assert when pointers differ only in the wrap bit; empty when equal; vld_out = ~empty.
REQ-017 A write SHALL occur when write_enb=1 and full=0; write_enb while full is ignored, even with a simultaneous read.
REQ-018 A read SHALL occur when read_enb=1 and empty=0; data_out updates on the next rising edge (1-cycle latency).
REQ-019 Simultaneous read and write when neither full nor empty SHALL both complete; occupancy unchanged.
REQ-020 Read while empty SHALL be ignored; data_out holds its last value.
REQ-021 Pointers SHALL wrap from DEPTH-1 to 0 and toggle the wrap bit.
REQ-022 On reading a word with bit 8 = 1, the packet counter (6 bits) SHALL load header[7:2] + 1 (payload plus parity).
REQ-023 On reading a non-header word with counter non-zero, the counter SHALL decrement by 1.
REQ-024 When the counter reaches 0 and FIFO is empty, data_out SHALL be driven 8'h00 on the following cycle.
REQ-025 Timeout counter SHALL increment each cycle vld_out=1 and read_enb=0; clear on any read or when empty.
REQ-026 When the timeout counter reaches TIMEOUT-1, next edge SHALL flush: pointers 0, packet counter 0, data_out 8'h00, soft_reset=1 for exactly one cycle.
REQ-027 A write in the flush cycle SHALL be discarded.

Reset
REQ-028 reset=1 at a rising edge SHALL set pointers 0, packet and timeout counters 0, data_out 8'h00, soft_reset 0.
REQ-029 After reset: empty=1, full=0, vld_out=0; memory contents need not be cleared.
REQ-030 Reset mid-packet SHALL abandon the packet; no partial state survives.

Configuration
REQ-031 Macro ROUTER_FIFO_TIMEOUT_EN defined: REQ-025..REQ-027 timeout flush included.
REQ-032 Macro ROUTER_FIFO_TIMEOUT_EN undefined: timeout logic absent, soft_reset tied 0, FIFO never self-flushes.

Structure
REQ-033 Package router_pkg SHALL hold DEPTH and TIMEOUT defaults, the 9-bit fifo_word_t typedef and header field positions (length [7:2], address [1:0]).
REQ-034 Single module, no sub-modules; the timeout counter is a natural separable sub-module router_fifo_timer if reuse is needed.

Verification
REQ-035 Reset, then write header 8'h0D (len 3) + 3 payload + parity, read all -> data_out matches order, empty=1 after 5th read.
REQ-036 Write 16 bytes -> full=1; 17th write ignored; read 16 -> 16 original bytes, empty=1.
REQ-037 Fill 12, read 8, write 10 -> pointers wrap, 14 bytes read back in order.
REQ-038 Write 1 byte, hold read_enb=0 30 cycles (macro defined) -> soft_reset pulses once on cycle 30, empty=1; macro undefined -> no flush.
REQ-039 Write 4 bytes, assert reset mid-read -> next cycle empty=1, data_out=8'h00, packet counter 0.
REQ-040 Simultaneous read and write at occupancy 5 -> occupancy stays 5, data order preserved.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and defaults for the router FIFO: 9-bit stored word with header flag,
// plus header field positions (length [7:2], address [1:0]).
package router_pkg;

    localparam int DEPTH_DEF    = 16;
    localparam int TIMEOUT_DEF  = 30;

    localparam int LFD_BIT      = 8;
    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    typedef logic [8:0] fifo_word_t;

    function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
        return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Router output FIFO with header-driven packet byte counter.
// Idle-timeout flush is built only when ROUTER_FIFO_TIMEOUT_EN is defined.
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       write_enb,
    input  logic       lfd_state,
    input  logic [7:0] data_in,
    input  logic       read_enb,
    output logic [7:0] data_out,
    output logic       vld_out,
    output logic       full,
    output logic       empty,
    output logic       soft_reset
);

    localparam int AW = $clog2(DEPTH);

    fifo_word_t  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [5:0]  pkt_cnt_q, pkt_cnt_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        empty_s, full_s, wr_en_s, rd_en_s, flush_s;
    fifo_word_t  rd_word_s;

    assign empty_s   = (wr_ptr_q == rd_ptr_q);
    assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_en_s   = write_enb & ~full_s & ~flush_s;
    assign rd_en_s   = read_enb & ~empty_s;
    assign rd_word_s = mem_q[rd_ptr_q[AW-1:0]];

`ifdef ROUTER_FIFO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmr_q, tmr_d;
    logic          soft_reset_q;

    // Flush fires on the edge that would complete TIMEOUT idle cycles.
    assign flush_s = ~empty_s & ~read_enb & (tmr_q == TW'(TIMEOUT - 1));

    always_comb begin
        tmr_d = tmr_q;
        if (flush_s || empty_s || read_enb) begin
            tmr_d = '0;
        end else begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tmr_q        <= '0;
            soft_reset_q <= 1'b0;
        end else begin
            tmr_q        <= tmr_d;
            soft_reset_q <= flush_s;
        end
    end

    assign soft_reset = soft_reset_q;
`else
    assign flush_s    = 1'b0;
    assign soft_reset = 1'b0;
`endif

    // Pointer, packet counter and output byte next-state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pkt_cnt_d  = pkt_cnt_q;
        data_out_d = data_out_q;
        if (flush_s) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pkt_cnt_d  = 6'd0;
            data_out_d = 8'h00;
        end else begin
            if (wr_en_s) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_en_s) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                data_out_d = rd_word_s[7:0];
                if (rd_word_s[LFD_BIT]) begin
                    pkt_cnt_d = hdr_len(rd_word_s[7:0]) + 6'd1;
                end else if (pkt_cnt_q != 6'd0) begin
                    pkt_cnt_d = pkt_cnt_q - 6'd1;
                end else begin
                    pkt_cnt_d = pkt_cnt_q;
                end
            end else if (empty_s && (pkt_cnt_q == 6'd0)) begin
                data_out_d = 8'h00;
            end else begin
                data_out_d = data_out_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= 6'd0;
            data_out_q <= 8'h00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage array is intentionally not cleared by reset.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    assign data_out = data_out_q;
    assign empty    = empty_s;
    assign full     = full_s;
    assign vld_out  = ~empty_s;

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_router_fifo;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 30;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       write_enb = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       read_enb = 1'b0;
    logic [7:0] data_out;
    logic       vld_out, full, empty, soft_reset;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] m_q[$];
    int         m_cnt  = 0;
    logic [7:0] m_dout = 8'h00;
    int         m_tmr  = 0;
    logic       m_soft = 1'b0;

    router_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .write_enb(write_enb), .lfd_state(lfd_state),
        .data_in(data_in), .read_enb(read_enb), .data_out(data_out), .vld_out(vld_out),
        .full(full), .empty(empty), .soft_reset(soft_reset)
    );

    always #5 clock = ~clock;

    // One clock: drive inputs, advance the reference model, settle past the edge.
    task automatic step(input bit we, input bit lfd, input logic [7:0] din,
                        input bit re, input bit rst);
        bit m_empty, m_full, flush;
        logic [8:0] w;
        m_empty = (m_q.size() == 0);
        m_full  = (m_q.size() == DEPTH);
        flush   = 1'b0;
`ifdef ROUTER_FIFO_TIMEOUT_EN
        flush = !m_empty && !re && (m_tmr == TIMEOUT - 1);
`endif
        write_enb = we; lfd_state = lfd; data_in = din; read_enb = re; reset = rst;
        @(posedge clock);
        if (rst || flush) begin
            m_q.delete(); m_cnt = 0; m_dout = 8'h00; m_tmr = 0;
            m_soft = flush && !rst;
        end else begin
            m_soft = 1'b0;
            m_tmr  = (m_empty || re) ? 0 : m_tmr + 1;
            if (re && !m_empty) begin
                w = m_q.pop_front();
                m_dout = w[7:0];
                if (w[8]) m_cnt = (int'(w[7:2]) + 1) % 64;
                else if (m_cnt != 0) m_cnt = m_cnt - 1;
            end else if (m_empty && m_cnt == 0) begin
                m_dout = 8'h00;
            end
            if (we && !m_full) m_q.push_back({lfd, din});
        end
        #1;
        write_enb = 1'b0; read_enb = 1'b0; reset = 1'b0; lfd_state = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (m_q.size() != 0) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'hAA, 1'b0, 1'b1);
        n_cmp++;
        if ({data_out, empty, full, vld_out, soft_reset} !== {8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state got dout=%h e=%b f=%b v=%b sr=%b want 00 1 0 0 0",
                     data_out, empty, full, vld_out, soft_reset);
        end
    endtask

    task automatic test_packet();
        logic [7:0] pkt [5];
        pkt[0] = 8'h0D; pkt[1] = 8'hA1; pkt[2] = 8'hB2; pkt[3] = 8'hC3;
        pkt[4] = pkt[0] ^ pkt[1] ^ pkt[2] ^ pkt[3];
        for (int i = 0; i < 5; i++) step(1'b1, (i == 0), pkt[i], 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            n_cmp++;
            if (data_out !== pkt[i]) begin
                n_err++;
                $display("FAIL packet_byte%0d got %h want %h", i, data_out, pkt[i]);
            end
        end
        n_cmp++;
        if (empty !== 1'b1) begin
            n_err++;
            $display("FAIL packet_empty got %b want 1", empty);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (data_out !== 8'h00) begin
            n_err++;
            $display("FAIL packet_end_zero got %h want 00", data_out);
        end
    endtask

    task automatic test_full();
        logic [7:0] exp [DEPTH];
        for (int i = 0; i < DEPTH; i++) begin
            exp[i] = 8'($urandom);
            step(1'b1, 1'b0, exp[i], 1'b0, 1'b0);
        end
        n_cmp++;
        if ({full, empty} !== 2'b10) begin
            n_err++;
            $display("FAIL full_flag got full=%b empty=%b want 1 0", full, empty);
        end
        step(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
        n_cmp++;
        if (data_out !== exp[0] || full !== 1'b0) begin
            n_err++;
            $display("FAIL full_write_ignored got dout=%h full=%b want %h 0", data_out, full, exp[0]);
        end
        for (int i = 1; i < DEPTH; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            n_cmp++;
            if (data_out !== exp[i]) begin
                n_err++;
                $display("FAIL full_read%0d got %h want %h", i, data_out, exp[i]);
            end
        end
        n_cmp++;
        if (empty !== 1'b1) begin
            n_err++;
            $display("FAIL full_drained_empty got %b want 1", empty);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp[$];
        logic [7:0] b, e;
        for (int i = 0; i < 12; i++) begin b = 8'($urandom); exp.push_back(b); step(1'b1, 1'b0, b, 1'b0, 1'b0); end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            e = exp.pop_front();
            n_cmp++;
            if (data_out !== e) begin n_err++; $display("FAIL wrap_read_a%0d got %h want %h", i, data_out, e); end
        end
        for (int i = 0; i < 10; i++) begin b = 8'($urandom); exp.push_back(b); step(1'b1, 1'b0, b, 1'b0, 1'b0); end
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            e = exp.pop_front();
            n_cmp++;
            if (data_out !== e) begin n_err++; $display("FAIL wrap_read_b%0d got %h want %h", i, data_out, e); end
        end
        n_cmp++;
        if (empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty got %b want 1", empty); end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int at = -1;
        drain();
        step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        for (int k = 1; k <= 35; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            if (soft_reset === 1'b1) begin pulses++; if (at < 0) at = k; end
        end
`ifdef ROUTER_FIFO_TIMEOUT_EN
        n_cmp++;
        if (pulses != 1 || at != 30 || empty !== 1'b1 || data_out !== 8'h00) begin
            n_err++;
            $display("FAIL timeout_flush got pulses=%0d at=%0d empty=%b dout=%h want 1 30 1 00",
                     pulses, at, empty, data_out);
        end
`else
        n_cmp++;
        if (pulses != 0 || empty !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_absent got pulses=%0d empty=%b want 0 0", pulses, empty);
        end
`endif
        drain();
    endtask

    task automatic test_reset_mid();
        drain();
        step(1'b1, 1'b1, 8'h14, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        n_cmp++;
        if ({empty, data_out} !== {1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL midreset_state got empty=%b dout=%h want 1 00", empty, data_out);
        end
        step(1'b1, 1'b0, 8'h44, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (data_out !== 8'h55) begin n_err++; $display("FAIL midreset_read got %h want 55", data_out); end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (data_out !== 8'h00) begin
            n_err++;
            $display("FAIL midreset_counter_cleared got dout=%h want 00", data_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[$];
        logic [7:0] b, e;
        drain();
        for (int i = 0; i < 5; i++) begin b = 8'($urandom); exp.push_back(b); step(1'b1, 1'b0, b, 1'b0, 1'b0); end
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            step(1'b1, 1'b0, b, 1'b1, 1'b0);
            e = exp.pop_front();
            exp.push_back(b);
            n_cmp++;
            if ({data_out, vld_out, full} !== {e, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL simul_rw%0d got dout=%h v=%b f=%b want %h 1 0", i, data_out, vld_out, full, e);
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            e = exp.pop_front();
            n_cmp++;
            if (data_out !== e) begin n_err++; $display("FAIL simul_drain%0d got %h want %h", i, data_out, e); end
        end
        n_cmp++;
        if (empty !== 1'b1) begin n_err++; $display("FAIL simul_occupancy got empty=%b want 1", empty); end
    endtask

    task automatic test_random();
        bit we, re, lfd, rst;
        for (int c = 0; c < 600; c++) begin
            we  = ($urandom_range(0, 99) < 55);
            re  = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 50 : 15));
            lfd = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 127) == 0);
            step(we, lfd, 8'($urandom), re, rst);
            n_cmp++;
            if ({data_out, empty, full, vld_out, soft_reset} !==
                {m_dout, (m_q.size() == 0), (m_q.size() == DEPTH), (m_q.size() != 0), m_soft}) begin
                n_err++;
                $display("FAIL random cyc %0d got dout=%h e=%b f=%b v=%b sr=%b want dout=%h e=%b f=%b v=%b sr=%b",
                         c, data_out, empty, full, vld_out, soft_reset, m_dout, (m_q.size() == 0),
                         (m_q.size() == DEPTH), (m_q.size() != 0), m_soft);
            end
        end
    endtask

    initial begin
        test_reset();
        test_packet();
        test_full();
        test_wrap();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
